// File: rtl/regfile_stack_ctrl.sv
// Push/pop sequencer for the stacked register file on interrupt entry and mret.
// Single-cycle stack commands, fetch stall, level tracking and sticky over/underflow flags.
module regfile_stack_ctrl #(
    parameter int Depth      = 4,
    parameter int LevelWidth = $clog2(Depth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  entry_req_i,
    input  logic                  exit_req_i,
    input  logic                  clear_err_i,
    output logic [1:0]            command_o,
    output logic                  stall_o,
    output logic                  ack_o,
    output logic [LevelWidth-1:0] level_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic [1:0]            state_o
);

    // Handshake: entry_req_i / exit_req_i act as valid and are held until ack_o;
    // ack_o is the one-cycle ready/completion pulse, and requests are only sampled in IDLE.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] CmdNone = 2'd0;
    localparam logic [1:0] CmdPush = 2'd1;
    localparam logic [1:0] CmdPop  = 2'd2;

    localparam logic [LevelWidth-1:0] LevelMax = LevelWidth'(Depth);
    localparam logic [LevelWidth-1:0] LevelOne = LevelWidth'(1);

    state_t state;

    assign full_o  = (level_o == LevelMax);
    assign empty_o = (level_o == '0);
    assign state_o = state;

    // Outputs are registered alongside the state, so each one is the value for the state being entered.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            command_o   <= CmdNone;
            stall_o     <= 1'b0;
            ack_o       <= 1'b0;
            level_o     <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            command_o <= CmdNone;
            ack_o     <= 1'b0;
            stall_o   <= 1'b1;

            // Placed before the case so that a same-cycle error set overrides the clear.
            if (clear_err_i) begin
                overflow_o  <= 1'b0;
                underflow_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (entry_req_i && !full_o) begin
                        state     <= PUSH;
                        command_o <= CmdPush;
                    end else if (entry_req_i) begin
                        state      <= DONE;
                        overflow_o <= 1'b1;
                        ack_o      <= 1'b1;
                    end else if (exit_req_i && !empty_o) begin
                        state     <= POP;
                        command_o <= CmdPop;
                    end else if (exit_req_i) begin
                        state       <= DONE;
                        underflow_o <= 1'b1;
                        ack_o       <= 1'b1;
                    end else begin
                        stall_o <= 1'b0;
                    end
                end
                PUSH: begin
                    if (level_o != LevelMax) begin
                        level_o <= level_o + LevelOne;
                    end
                    state <= DONE;
                    ack_o <= 1'b1;
                end
                POP: begin
                    if (level_o != '0) begin
                        level_o <= level_o - LevelOne;
                    end
                    state <= DONE;
                    ack_o <= 1'b1;
                end
                DONE: begin
                    state   <= IDLE;
                    stall_o <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    stall_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_stack_ctrl.sv
// Directed bench for regfile_stack_ctrl with Depth = 4: push/pop latency, full/overflow,
// underflow and clear, entry-over-exit priority, and asynchronous reset during a push.
module tb_regfile_stack_ctrl;

    logic       clk;
    logic       rst;
    logic       entry_req;
    logic       exit_req;
    logic       clear_err;
    logic [1:0] command;
    logic       stall;
    logic       ack;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       underflow;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    regfile_stack_ctrl #(.Depth(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .entry_req_i (entry_req),
        .exit_req_i  (exit_req),
        .clear_err_i (clear_err),
        .command_o   (command),
        .stall_o     (stall),
        .ack_o       (ack),
        .level_o     (level),
        .full_o      (full),
        .empty_o     (empty),
        .overflow_o  (overflow),
        .underflow_o (underflow),
        .state_o     (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // driver and checking tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A request that is served: command cycle, ack cycle, back in IDLE.
    task automatic valid_op(input bit is_entry, input int lvl_before);
        int lvl_after;
        lvl_after = is_entry ? lvl_before + 1 : lvl_before - 1;
        if (is_entry) entry_req = 1'b1;
        else exit_req = 1'b1;
        tick();
        check("op_cmd",        command, is_entry ? 1 : 2);
        check("op_cmd_stall",  stall, 1);
        check("op_cmd_ack",    ack, 0);
        check("op_cmd_level",  level, lvl_before);
        tick();
        check("op_ack",        ack, 1);
        check("op_ack_cmd",    command, 0);
        check("op_ack_stall",  stall, 1);
        check("op_ack_level",  level, lvl_after);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        tick();
        check("op_idle_stall", stall, 0);
        check("op_idle_ack",   ack, 0);
        check("op_idle_state", state, 0);
    endtask

    initial begin
        rst       = 1'b0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        clear_err = 1'b0;

        // reset values
        #2;
        check("rst_cmd",   command, 0);
        check("rst_stall", stall, 0);
        check("rst_ack",   ack, 0);
        check("rst_level", level, 0);
        check("rst_full",  full, 0);
        check("rst_empty", empty, 1);
        check("rst_ovf",   overflow, 0);
        check("rst_unf",   underflow, 0);
        check("rst_state", state, 0);
        tick();
        rst = 1'b1;
        tick();

        // fill to Depth
        valid_op(1'b1, 0);
        check("lvl1_empty", empty, 0);
        valid_op(1'b1, 1);
        valid_op(1'b1, 2);
        valid_op(1'b1, 3);
        check("fill_full",  full, 1);
        check("fill_empty", empty, 0);

        // fifth entry overflows: no push, ack next cycle, level held
        entry_req = 1'b1;
        tick();
        check("ovf_flag",  overflow, 1);
        check("ovf_cmd",   command, 0);
        check("ovf_ack",   ack, 1);
        check("ovf_level", level, 4);
        check("ovf_stall", stall, 1);
        check("ovf_state", state, 3);
        entry_req = 1'b0;
        tick();
        check("ovf_idle_stall", stall, 0);
        check("ovf_idle_ack",   ack, 0);
        check("ovf_sticky",     overflow, 1);
        check("ovf_full",       full, 1);

        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("ovf_cleared", overflow, 0);

        // drain
        valid_op(1'b0, 4);
        valid_op(1'b0, 3);
        valid_op(1'b0, 2);
        valid_op(1'b0, 1);
        check("drain_empty", empty, 1);
        check("drain_ovf",   overflow, 0);
        check("drain_unf",   underflow, 0);

        // underflow from empty
        exit_req = 1'b1;
        tick();
        check("unf_flag",  underflow, 1);
        check("unf_cmd",   command, 0);
        check("unf_ack",   ack, 1);
        check("unf_level", level, 0);
        exit_req = 1'b0;
        tick();
        check("unf_idle_ack", ack, 0);
        check("unf_sticky",   underflow, 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("unf_cleared", underflow, 0);

        // set beats a same-cycle clear
        exit_req  = 1'b1;
        clear_err = 1'b1;
        tick();
        check("setwins_unf", underflow, 1);
        exit_req  = 1'b0;
        clear_err = 1'b0;
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("setwins_cleared", underflow, 0);

        // entry and exit together at level 1: push first, pop afterwards
        valid_op(1'b1, 0);
        entry_req = 1'b1;
        exit_req  = 1'b1;
        tick();
        check("both_cmd_push", command, 1);
        tick();
        check("both_ack1",   ack, 1);
        check("both_level2", level, 2);
        entry_req = 1'b0;
        tick();
        check("both_idle_cmd",   command, 0);
        check("both_idle_stall", stall, 0);
        tick();
        check("both_cmd_pop", command, 2);
        check("both_pop_lvl", level, 2);
        tick();
        check("both_ack2",   ack, 1);
        check("both_level1", level, 1);
        exit_req = 1'b0;
        tick();
        check("both_end_stall", stall, 0);
        check("both_end_err",   {overflow, underflow}, 0);

        // asynchronous reset during a PUSH at level 2
        valid_op(1'b1, 1);
        entry_req = 1'b1;
        tick();
        check("arst_pre_cmd", command, 1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_cmd",   command, 0);
        check("arst_stall", stall, 0);
        check("arst_level", level, 0);
        check("arst_empty", empty, 1);
        check("arst_ack",   ack, 0);
        check("arst_state", state, 0);
        entry_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        valid_op(1'b1, 0);
        check("arst_after_level", level, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
